// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, FSM state type, S-box tables and key-schedule helpers.
package aes_pkg;

  localparam int NUM_ROUNDS_128 = 10;

  typedef enum logic [2:0] {IDLE, KEXP, LOAD, ROUND, FINAL, DONE} state_t;

  // Byte 0 of each table sits in the top 8 bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] forward_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo forward_step: recover the older w3 first, since the new w0 depends on it.
  function automatic logic [127:0] inverse_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless is_last_round is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] in_state,
  input  logic [127:0] round_key,
  input  logic         is_last_round,
  output logic [127:0] out_state
);

  function automatic logic [7:0] bsel(input logic [127:0] s, input logic [3:0] i);
    return s[{~i, 3'b000} +: 8];
  endfunction

  // Column-major state: byte r+4c is row r, column c; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {bsel(s, 4'd0),  bsel(s, 4'd13), bsel(s, 4'd10), bsel(s, 4'd7),
            bsel(s, 4'd4),  bsel(s, 4'd1),  bsel(s, 4'd14), bsel(s, 4'd11),
            bsel(s, 4'd8),  bsel(s, 4'd5),  bsel(s, 4'd2),  bsel(s, 4'd15),
            bsel(s, 4'd12), bsel(s, 4'd9),  bsel(s, 4'd6),  bsel(s, 4'd3)};
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  logic [127:0] shifted, subbed, keyed;

  always_comb begin
    shifted   = inv_shift_rows(in_state);
    subbed    = {inv_sub_word(shifted[127:96]), inv_sub_word(shifted[95:64]),
                 inv_sub_word(shifted[63:32]),  inv_sub_word(shifted[31:0])};
    keyed     = subbed ^ round_key;
    out_state = is_last_round ? keyed
                              : {inv_mix_col(keyed[127:96]), inv_mix_col(keyed[95:64]),
                                 inv_mix_col(keyed[63:32]),  inv_mix_col(keyed[31:0])};
  end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption core: forward key expansion to rk10, then one inverse round per clock.
// Optional last-round-key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_iterative
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("aes_decrypt_iterative supports only NUM_ROUNDS = 10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS_128);

  state_t       fsm_q, fsm_d;
  logic [127:0] ct_q, ct_d, key_q, key_d, st_q, st_d, out_q, out_d;
  logic [3:0]   round_q, round_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] round_out;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cached_key_q, cached_key_d, cached_rk10_q, cached_rk10_d;
  logic         cache_valid_q, cache_valid_d;
`endif

  aes_inv_round u_inv_round (
    .in_state      (st_q),
    .round_key     (key_q),
    .is_last_round (fsm_q == FINAL),
    .out_state     (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    ct_d        = ct_q;
    key_d       = key_q;
    st_d        = st_q;
    out_d       = out_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cached_key_d  = cached_key_q;
    cached_rk10_d = cached_rk10_q;
    cache_valid_d = cache_valid_q;
`endif
    case (fsm_q)
      IDLE: if (in_valid) begin
        ct_d    = in_data;
        key_d   = in_key;
        round_d = 4'd1;
        fsm_d   = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
        if (cache_valid_q && (in_key == cached_key_q)) begin
          key_d = cached_rk10_q;
          fsm_d = LOAD;
        end else begin
          cached_key_d  = in_key;
          cache_valid_d = 1'b0;
        end
`endif
      end
      KEXP: begin
        key_d = forward_step(key_q, rcon(round_q));
        if (round_q == LAST_ROUND) begin
          fsm_d = LOAD;
`ifdef AES_DEC_KEY_CACHE_EN
          cached_rk10_d = key_d;
          cache_valid_d = 1'b1;
`endif
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      LOAD: begin
        st_d    = ct_q ^ key_q;
        key_d   = inverse_step(key_q, rcon(LAST_ROUND));
        round_d = 4'd9;
        fsm_d   = ROUND;
      end
      // Key register always holds the key for the round being applied this cycle.
      ROUND: begin
        st_d    = round_out;
        key_d   = inverse_step(key_q, rcon(round_q));
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        out_d       = round_out;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      ct_q        <= '0;
      key_q       <= '0;
      st_q        <= '0;
      out_q       <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cached_key_q  <= '0;
      cached_rk10_q <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      ct_q        <= ct_d;
      key_q       <= key_d;
      st_q        <= st_d;
      out_q       <= out_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cached_key_q  <= cached_key_d;
      cached_rk10_q <= cached_rk10_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Self-checking bench for aes_decrypt_iterative; expected plaintexts come from an independent
// AES-128 encryption model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_decrypt_iterative;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int FULL_LAT = 21;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif
  localparam int WAIT_MAX = 64;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, in_key, out_data;
  int           n_checks, n_pass;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];

  aes_decrypt_iterative #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[7'(8 * (15 - i)) +: 8];
  endfunction

  function automatic logic [127:0] sbv(input logic [127:0] v, input int i, input logic [7:0] b);
    v[7'(8 * (15 - i)) +: 8] = b;
    return v;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      x = inv;
      sbox_t[8'(a)] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                      ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk [16];
    logic [127:0] s, t;
    logic [31:0]  w0, w1, w2, w3, tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk[0] = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      {w0, w1, w2, w3} = rk[4'(r - 1)];
      tw = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ tw; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk[4'(r)] = {w0, w1, w2, w3};
      rc = gmul(rc, 8'h02);
    end
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      t = s;
      for (int i = 0; i < 16; i++) t = sbv(t, i, sbox_t[gb(s, i)]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s = sbv(s, rr + 4 * c, gb(t, rr + 4 * ((c + rr) % 4)));
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = gb(s, 4 * c); a1 = gb(s, 4 * c + 1); a2 = gb(s, 4 * c + 2); a3 = gb(s, 4 * c + 3);
          s = sbv(s, 4 * c,     gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3);
          s = sbv(s, 4 * c + 1, a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3);
          s = sbv(s, 4 * c + 2, a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03));
          s = sbv(s, 4 * c + 3, gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02));
        end
      end
      s = s ^ rk[4'(r)];
    end
    return s;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_block(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = key;
    exp_q.push_back(pt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_out(input bit jitter, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < WAIT_MAX) begin
      if (jitter) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, want 0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 128'h0) $display("FAIL reset_out_data: got %h, want 0", out_data); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, want 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips_c1();
    int lat;
    logic [127:0] exp;
    send_block(C1_KEY, C1_CT, C1_PT);
    wait_out(1'b0, lat);
    exp = pop_exp();
    n_checks++;
    if (lat !== FULL_LAT) $display("FAIL c1_latency: got %0d edges, want %0d", lat, FULL_LAT); else n_pass++;
    n_checks++;
    if (out_data !== exp) $display("FAIL c1_data: got %h, want %h", out_data, exp); else n_pass++;
    release_out();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL c1_in_ready_after: got %b, want 1", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL c1_out_valid_after: got %b, want 0", out_valid); else n_pass++;
  endtask

  task automatic test_fips_b();
    int lat;
    logic [127:0] exp;
    send_block(B_KEY, B_CT, B_PT);
    wait_out(1'b0, lat);
    exp = pop_exp();
    n_checks++;
    if (lat !== FULL_LAT) $display("FAIL b_latency: got %0d edges, want %0d", lat, FULL_LAT); else n_pass++;
    n_checks++;
    if (out_data !== exp) $display("FAIL b_data: got %h, want %h", out_data, exp); else n_pass++;
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    logic [127:0] exp;
    send_block(C1_KEY, C1_CT, C1_PT);
    wait_out(1'b0, lat);
    exp = pop_exp();
    n_checks++;
    if (out_data !== exp) $display("FAIL bp_data: got %h, want %h", out_data, exp); else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL bp_hold: got data %h valid %b in_ready %b, want %h 1 0",
                          out_data, out_valid, in_ready, exp);
    else n_pass++;
    release_out();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: got in_ready %b out_valid %b, want 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit quiet;
    logic [127:0] exp;
    send_block(B_KEY, B_CT, B_PT);
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL mid_busy_in_ready: got %b, want 0", in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0)
      $display("FAIL mid_reset_outputs: got valid %b data %h, want 0 0", out_valid, out_data);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b, want 1", in_ready); else n_pass++;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL mid_no_output: got out_valid 1 after abandoned block, want 0"); else n_pass++;
    send_block(C1_KEY, C1_CT, C1_PT);
    wait_out(1'b0, lat);
    exp = pop_exp();
    n_checks++;
    if (out_data !== exp || lat !== FULL_LAT)
      $display("FAIL mid_next_block: got %h after %0d edges, want %h after %0d", out_data, lat, exp, FULL_LAT);
    else n_pass++;
    release_out();
  endtask

  task automatic test_key_cache();
    logic [127:0] keys [4];
    logic [127:0] cts  [4];
    logic [127:0] pts  [4];
    int           lats [4];
    int           lat;
    logic [127:0] exp;
    keys = '{C1_KEY, C1_KEY, B_KEY, B_KEY};
    cts  = '{C1_CT,  C1_CT,  B_CT,  B_CT};
    pts  = '{C1_PT,  C1_PT,  B_PT,  B_PT};
    lats = '{FULL_LAT, HIT_LAT, FULL_LAT, HIT_LAT};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send_block(keys[i], cts[i], pts[i]);
      wait_out(1'b0, lat);
      exp = pop_exp();
      n_checks++;
      if (lat !== lats[i]) $display("FAIL cache_latency_%0d: got %0d edges, want %0d", i, lat, lats[i]);
      else n_pass++;
      n_checks++;
      if (out_data !== exp) $display("FAIL cache_data_%0d: got %h, want %h", i, out_data, exp); else n_pass++;
      release_out();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] key, pt, exp;
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_block(key, aes_encrypt(key, pt), pt);
      wait_out(1'b1, lat);
      exp = pop_exp();
      n_checks++;
      if (lat !== FULL_LAT) $display("FAIL rand_latency_%0d: got %0d edges, want %0d", i, lat, FULL_LAT);
      else n_pass++;
      n_checks++;
      if (out_data !== exp) $display("FAIL rand_data_%0d: got %h, want %h", i, out_data, exp); else n_pass++;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      release_out();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    build_sbox();
    @(posedge clk);
    #1;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_reset_mid_run();
    test_key_cache();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
